// File: rtl/nios_nios2_qsys_0_mul_seq_pkg.sv
// Shared types and constants for the multi-cycle multiply sequencer.
package nios_mul_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_RESP
  } state_e;

  // Bit 1 selects the high half of a, bit 0 selects the high half of b.
  typedef enum logic [1:0] {
    SEL_LL = 2'b00,
    SEL_LH = 2'b01,
    SEL_HL = 2'b10,
    SEL_HH = 2'b11
  } pass_sel_e;

  localparam logic [2:0] PASSES_MUL = 3'd2;
  localparam logic [2:0] PASSES_HI  = 3'd4;

  // Unsigned partial sums give the high word of a*b; signed operands need
  // the usual subtract-the-other-operand correction.
  function automatic logic [31:0] fix_result(input op_e op, input logic [63:0] acc,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] res;
    hi     = acc[63:32];
    corr_a = a[31] ? b : 32'd0;
    corr_b = b[31] ? a : 32'd0;
    case (op)
      OP_MUL:    res = acc[31:0];
      OP_MULXUU: res = hi;
      OP_MULXSU: res = hi - corr_a;
      default:   res = hi - corr_a - corr_b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nios_nios2_qsys_0_mult_cell.sv
// Registered 32x16 partial-product cell; src2 arrives zero-extended from a 16-bit half.
module nios_nios2_qsys_0_mult_cell (
  input  logic        clk,
  input  logic        aclr,
  input  logic        clken,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      result <= '0;
    end else if (clken) begin
      result <= src1 * src2;
    end
  end

endmodule

// File: rtl/nios_nios2_qsys_0_mul_seq.sv
// Multiply sequencer: 2 or 4 passes through one mult cell, 64-bit accumulate,
// signed correction in FIX, valid/ready on command and response sides.
module nios_nios2_qsys_0_mul_seq
  import nios_mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_src1,
  input  logic [31:0] cmd_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result
);

  state_e      state;
  state_e      state_next;
  op_e         op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc;
  logic [2:0]  pass_cnt;
  logic [2:0]  num_passes;
  logic        accept;
  logic        last_pass;
  pass_sel_e   issue_sel;
  pass_sel_e   capture_sel;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic [31:0] cell_result;
  logic [63:0] addend;

  assign cmd_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign accept     = cmd_ready & cmd_valid & ~flush;
  assign num_passes = (op_q == OP_MUL) ? PASSES_MUL : PASSES_HI;
  assign last_pass  = (pass_cnt == num_passes);

  // In RUN cycle k, pass k is issued while the result of pass k-1 is captured.
  assign issue_sel   = pass_sel_e'(pass_cnt[1:0]);
  assign capture_sel = pass_sel_e'(pass_cnt[1:0] - 2'd1);

  always_comb begin
    cell_src1 = {16'd0, a_q[15:0]};
    cell_src2 = {16'd0, b_q[15:0]};
    if (op_q == OP_MUL) begin
      cell_src1 = a_q;
    end else if (issue_sel[1]) begin
      cell_src1 = {16'd0, a_q[31:16]};
    end
    if (issue_sel[0]) begin
      cell_src2 = {16'd0, b_q[31:16]};
    end
  end

  always_comb begin
    addend = {16'd0, cell_result, 16'd0};
    case (capture_sel)
      SEL_LL:  addend = {32'd0, cell_result};
      SEL_HH:  addend = {cell_result, 32'd0};
      default: addend = {16'd0, cell_result, 16'd0};
    endcase
  end

  nios_nios2_qsys_0_mult_cell u_cell (
    .clk    (clk),
    .aclr   (~reset_n),
    .clken  (1'b1),
    .src1   (cell_src1),
    .src2   (cell_src2),
    .result (cell_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_next = ST_RUN;
      ST_RUN:  if (last_pass) state_next = ST_FIX;
      ST_FIX:  state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      pass_cnt   <= '0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        op_q     <= op_e'(cmd_op);
        a_q      <= cmd_src1;
        b_q      <= cmd_src2;
        acc      <= '0;
        pass_cnt <= '0;
      end else if (state == ST_RUN && !flush) begin
        pass_cnt <= pass_cnt + 3'd1;
        if (pass_cnt != 3'd0) begin
          acc <= acc + addend;
        end
      end
      if (state == ST_FIX && !flush) begin
        rsp_result <= fix_result(op_q, acc, a_q, b_q);
      end
    end
  end

endmodule

// File: tb/tb_nios_nios2_qsys_0_mul_seq.sv
// Self-checking bench: directed cases plus random ops against a 64-bit product model.
module tb_nios_nios2_qsys_0_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_src1;
  logic [31:0] cmd_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  int checks   = 0;
  int failures = 0;

  nios_nios2_qsys_0_mul_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src1   (cmd_src1),
    .cmd_src2   (cmd_src2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Full signed/unsigned 64-bit product, then pick the word the op asks for.
  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] p;
    sa = (op[1]) ? {{32{a[31]}}, a} : {32'd0, a};
    sb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Issue one command, measure latency, optionally stall the response, then handshake.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_result, input int stall);
    int edges;
    @(negedge clk);
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src1  = a;
    cmd_src2  = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("latency", 64'(edges), (op == 2'b00) ? 64'd4 : 64'd6);
    checkOutput("result", 64'(rsp_result), 64'(exp_result));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (i == stall / 2) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_src1  = $urandom;
        cmd_src2  = $urandom;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checkOutput("stall_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall_result", 64'(rsp_result), 64'(exp_result));
      checkOutput("stall_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("hs_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("hs_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    reset_n   = 1'b0;
    flush     = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_op    = 2'b00;
    cmd_src1  = '0;
    cmd_src2  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_result", 64'(rsp_result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    applyStimulus(2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 0);

    // Long stall with a stray command, then a back-to-back command.
    applyStimulus(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, refModel(2'b00, 32'h1234_5678, 32'h9ABC_DEF0), 10);
    applyStimulus(2'b11, 32'h8000_0000, 32'h7FFF_FFFF, refModel(2'b11, 32'h8000_0000, 32'h7FFF_FFFF), 0);

    // Flush in RUN pass 2 with a competing command.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_src1  = 32'hDEAD_BEEF;
    cmd_src2  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush     = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("flush_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("flush_no_rsp", 64'(rsp_valid), 64'd0);
    end
    applyStimulus(2'b00, 32'd3, 32'd5, 32'h0000_000F, 0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_src1  = 32'h0F0F_0F0F;
    cmd_src2  = 32'hF0F0_F0F0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("async_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("async_rsp_result", 64'(rsp_result), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
    end

    for (int n = 0; n < 1000; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'h8000_0000;
        2: a = 32'h0;
        default: ;
      endcase
      applyStimulus(op, a, b, refModel(op, a, b), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
